// File: rtl/arb_mux21_wrr_pkg.sv
// Shared state encodings, word field offsets and default weights for the
// arb_mux21_wrr 2:1 weighted round-robin scheduler.
package arb_mux21_wrr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE0 = 2'd1,
    ST_SERVE1 = 2'd2
  } arb_state_e;

  localparam int CLASS_MSB   = 9;
  localparam int CLASS_LSB   = 8;
  localparam int PAYLOAD_MSB = 7;

  localparam int DEF_WEIGHT0 = 2;
  localparam int DEF_WEIGHT1 = 2;
  localparam int DEF_CNT_W   = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arb_mux21_wrr_if.sv
// FIFO-side and egress-side signal bundle of arb_mux21_wrr.
// The grant counters exist only when ARB_GRANT_CNT_EN is defined.
interface arb_mux21_wrr_if #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 8
);
  logic              fifo0_empty;
  logic              fifo1_empty;
  logic [DATA_W-1:0] fifo0_data;
  logic [DATA_W-1:0] fifo1_data;
  logic              down_almost_full;
  logic              pop0;
  logic              pop1;
  logic [OUT_W-1:0]  out;
  logic [1:0]        out_class;
  logic              valid_out;
  logic              grant;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0]       grant0_cnt;
  logic [15:0]       grant1_cnt;

  modport slave (
    input  fifo0_empty, fifo1_empty, fifo0_data, fifo1_data, down_almost_full,
    output pop0, pop1, out, out_class, valid_out, grant, grant0_cnt, grant1_cnt
  );
  modport master (
    output fifo0_empty, fifo1_empty, fifo0_data, fifo1_data, down_almost_full,
    input  pop0, pop1, out, out_class, valid_out, grant, grant0_cnt, grant1_cnt
  );
`else
  modport slave (
    input  fifo0_empty, fifo1_empty, fifo0_data, fifo1_data, down_almost_full,
    output pop0, pop1, out, out_class, valid_out, grant
  );
  modport master (
    output fifo0_empty, fifo1_empty, fifo0_data, fifo1_data, down_almost_full,
    input  pop0, pop1, out, out_class, valid_out, grant
  );
`endif
endinterface

// File: rtl/arb_mux21_wrr_out_stage.sv
// Output stage: delays the pop strobe to line up with FIFO read data, then
// registers the selected word as payload/class with a valid flag.
module arb_mux21_wrr_out_stage
  import arb_mux21_wrr_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pop0_i,
  input  logic              pop1_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic [OUT_W-1:0]  out_o,
  output logic [1:0]        class_o,
  output logic              valid_o
);

  logic              pop_q;
  logic              src_q;
  logic [DATA_W-1:0] word_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [1:0]        class_q, class_d;
  logic              valid_q;

  // Select the word read last cycle; hold the outputs when nothing arrives.
  always_comb begin
    word_d = src_q ? data1_i : data0_i;
    if (pop_q) begin
      out_d   = word_d[PAYLOAD_MSB:0];
      class_d = word_d[CLASS_MSB:CLASS_LSB];
    end else begin
      out_d   = out_q;
      class_d = class_q;
    end
  end

  // Pipeline registers; reset drops any word still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q   <= 1'b0;
      src_q   <= 1'b0;
      out_q   <= {OUT_W{1'b0}};
      class_q <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      pop_q   <= pop0_i | pop1_i;
      src_q   <= pop1_i;
      out_q   <= out_d;
      class_q <= class_d;
      valid_q <= pop_q;
    end
  end

  assign out_o   = out_q;
  assign class_o = class_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/arb_mux21_wrr.sv
// 2:1 weighted round-robin scheduler draining two ingress FIFOs into one egress
// stream. Define ARB_GRANT_CNT_EN to add saturating per-source pop counters.
module arb_mux21_wrr
  import arb_mux21_wrr_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int OUT_W   = 8,
  parameter int WEIGHT0 = DEF_WEIGHT0,
  parameter int WEIGHT1 = DEF_WEIGHT1,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  arb_mux21_wrr_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic             pop0_s, pop1_s;
  logic [CNT_W-1:0] wcnt_inc_s;
  logic             cur_s, own_empty_s, oth_empty_s, turn_end_s;
  arb_state_e       oth_st_s;

  assign pop0_s = (state_q == ST_SERVE0) & ~bus.fifo0_empty & ~bus.down_almost_full & ~reset;
  assign pop1_s = (state_q == ST_SERVE1) & ~bus.fifo1_empty & ~bus.down_almost_full & ~reset;

  // Both SERVE states share one body, expressed relative to the served side.
  assign wcnt_inc_s  = wcnt_q + CNT_W'(1'b1);
  assign cur_s       = (state_q == ST_SERVE1);
  assign own_empty_s = cur_s ? bus.fifo1_empty : bus.fifo0_empty;
  assign oth_empty_s = cur_s ? bus.fifo0_empty : bus.fifo1_empty;
  assign turn_end_s  = cur_s ? (wcnt_inc_s == CNT_W'(WEIGHT1)) : (wcnt_inc_s == CNT_W'(WEIGHT0));
  assign oth_st_s    = cur_s ? ST_SERVE0 : ST_SERVE1;

  // Next-state, weight counter and turn bookkeeping.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.fifo0_empty && !bus.fifo1_empty) begin
          state_d = last_q ? ST_SERVE0 : ST_SERVE1;
          grant_d = ~last_q;
          wcnt_d  = {CNT_W{1'b0}};
        end else if (!bus.fifo0_empty) begin
          state_d = ST_SERVE0;
          grant_d = 1'b0;
          wcnt_d  = {CNT_W{1'b0}};
        end else if (!bus.fifo1_empty) begin
          state_d = ST_SERVE1;
          grant_d = 1'b1;
          wcnt_d  = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE0, ST_SERVE1: begin
        if (bus.down_almost_full) begin
          state_d = state_q;
        end else if (own_empty_s) begin
          wcnt_d = {CNT_W{1'b0}};
          last_d = cur_s;
          if (!oth_empty_s) begin
            state_d = oth_st_s;
            grant_d = ~cur_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (turn_end_s) begin
          // Hand over only when the other side has work; else keep serving.
          wcnt_d = {CNT_W{1'b0}};
          if (!oth_empty_s) begin
            state_d = oth_st_s;
            grant_d = ~cur_s;
            last_d  = cur_s;
          end else begin
            state_d = state_q;
          end
        end else begin
          wcnt_d = wcnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= {CNT_W{1'b0}};
      last_q  <= 1'b1;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign bus.pop0  = pop0_s;
  assign bus.pop1  = pop1_s;
  assign bus.grant = grant_q;

  arb_mux21_wrr_out_stage #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W)
  ) u_out_stage (
    .clk    (clk),
    .reset  (reset),
    .pop0_i (pop0_s),
    .pop1_i (pop1_s),
    .data0_i(bus.fifo0_data),
    .data1_i(bus.fifo1_data),
    .out_o  (bus.out),
    .class_o(bus.out_class),
    .valid_o(bus.valid_out)
  );

`ifdef ARB_GRANT_CNT_EN
  logic [15:0] gcnt0_q, gcnt1_q;

  // Saturating per-source pop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt0_q <= 16'h0000;
      gcnt1_q <= 16'h0000;
    end else begin
      gcnt0_q <= pop0_s ? sat_inc16(gcnt0_q) : gcnt0_q;
      gcnt1_q <= pop1_s ? sat_inc16(gcnt1_q) : gcnt1_q;
    end
  end

  assign bus.grant0_cnt = gcnt0_q;
  assign bus.grant1_cnt = gcnt1_q;
`endif

endmodule

// File: doc/arb_mux21_wrr.md
Name: arb_mux21_wrr

Overview:
- Weighted round-robin scheduler for the 2:1 switch output stage. It drains two upstream FIFOs, one per ingress, into a single egress stream.
- Generates the FIFO read strobes (pop0/pop1) and steers the selected 10-bit FIFO word onto the 8-bit payload and 2-bit class outputs.
- Observes downstream almost-full backpressure.
- Sits between the ingress FIFOs and the egress FIFO of the switch.

Parameters:
- DATA_W, 10, FIFO word width: payload in [7:0], class in [9:8].
- OUT_W, 8, payload output width.
- WEIGHT0, 2, max consecutive pops from FIFO0 per turn; range 1..15.
- WEIGHT1, 2, max consecutive pops from FIFO1 per turn; range 1..15.
- CNT_W, 4, weight counter width.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- fifo0_empty  in  1  FIFO0 empty flag.
- fifo1_empty  in  1  FIFO1 empty flag.
- fifo0_data  in  DATA_W  FIFO0 read data; valid the cycle after pop0.
- fifo1_data  in  DATA_W  FIFO1 read data; valid the cycle after pop1.
- down_almost_full  in  1  egress FIFO almost-full; blocks new pops.
- pop0  out  1  read strobe to FIFO0 (combinational).
- pop1  out  1  read strobe to FIFO1 (combinational).
- out  out  OUT_W  registered payload.
- out_class  out  2  registered class bits [9:8].
- valid_out  out  1  out/out_class hold a new word this cycle.
- grant  out  1  source of the current turn (0/1), registered.

Behaviour:
- Single clock domain "clk". Synchronous active-high "reset".
- FSM states: IDLE=0, SERVE0=1, SERVE1=2. Reset -> IDLE, wcnt=0, last_served=1, grant=0, out=0, out_class=0, valid_out=0, pop_d=0.
- pop0 = (state==SERVE0) & ~fifo0_empty & ~down_almost_full & ~reset. pop1 uses SERVE1 and fifo1_empty in the same way. pop0 and pop1 are never both high.
- IDLE:
  - Both FIFOs empty: stay in IDLE.
  - Only one FIFO non-empty: go to that FIFO's SERVE state.
  - Both non-empty: go to SERVE(~last_served).
  - wcnt is cleared on entry to any SERVE state. grant is updated on entry.
- SERVEk, when popk=1:
  - wcnt increments.
  - If wcnt+1==WEIGHTk or the FIFO is going empty (fifok_empty at next edge is not known, so this is evaluated on the next cycle): end the turn.
- Turn end from SERVEk (wcnt reached WEIGHTk), evaluated at the same edge as the final pop:
  - Other FIFO non-empty: go to SERVE(other) with wcnt=0 and last_served=k.
  - Other FIFO empty: stay in SERVEk with wcnt=0 (work-conserving).
- SERVEk with fifok_empty=1:
  - Other FIFO non-empty: go to SERVE(other).
  - Both empty: go to IDLE, last_served=k.
- down_almost_full=1: no pops, state and wcnt frozen. Already-issued pops still complete through the output stage.
- Output stage:
  - pop_d <= pop0|pop1 and src_d <= pop1, registered at edge N.
  - At edge N+1, if pop_d: out <= selected fifo_data[7:0], out_class <= selected fifo_data[9:8], valid_out <= 1. Otherwise valid_out <= 0 and out/out_class hold.
  - Latency: pop in cycle N -> valid_out in cycle N+2. Peak throughput is 1 word/cycle. Turn switches add no bubble; IDLE->SERVE adds 1 bubble.
- Reset mid-operation: any word in flight (pop_d) is discarded and valid_out drops the cycle after reset is sampled.

Optional Feature:
- ARB_GRANT_CNT_EN:
  - Defined: adds outputs grant0_cnt[15:0] and grant1_cnt[15:0], counting pops per source. Counters saturate at 16'hFFFF and are cleared by reset.
  - Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared include arb_defs.v holds:
  - State encodings ST_IDLE, ST_SERVE0, ST_SERVE1.
  - Field offsets CLASS_MSB=9, CLASS_LSB=8, PAYLOAD_MSB=7.
  - Default weights.
- One natural sub-module, arb_out_stage: pop_d/src_d registers, data select, out/out_class/valid_out registers. It is reusable by a future 4:1 scheduler.

Test Plan:
- Both FIFOs hold 6 words, WEIGHT0=WEIGHT1=2, no backpressure:
  - Required pop order: 0,0,1,1,0,0,1,1,0,0,1,1.
  - First pop0 one cycle after reset release; valid_out two cycles after each pop.
- Only FIFO1 has 5 words (0x1A5, 0x2B6, ...):
  - 5 consecutive pop1 with no gap.
  - out=0xA5,0xB6,... and out_class=2'b01,2'b10,...; grant stays 1.
- down_almost_full asserted for 3 cycles mid-turn after the first pop0:
  - pop0/pop1 low for those 3 cycles.
  - Second pop0 resumes after deassertion; wcnt is preserved, so the turn still ends after 2 pops.
- FIFO0 goes empty after 1 word in SERVE0 while FIFO1 is non-empty:
  - Immediate switch to SERVE1; pop1 appears the cycle after the empty flag is seen.
- reset pulsed for 1 cycle during continuous traffic:
  - pops low that cycle; valid_out=0 and out=0 on the following cycle.
  - After release, the first pop goes to FIFO0.
- ARB_GRANT_CNT_EN defined, 10 words each side:
  - grant0_cnt=10 and grant1_cnt=10 at the end.
  - Forcing 70000 pops on FIFO0 leaves grant0_cnt=16'hFFFF.
